modn_counter: RTL and testbench

Parametrised modulo-N up/down counter that generalises the fixed 2-bit increment-only counter. It is used for sequencing and timing inside the LC-3 datapath: state-phase counters, cycle timers, and cascaded multi-digit counters. It adds arbitrary modulus, decrement, synchronous load, terminal-count outputs for cascading, and registered wrap pulses.

---
 rtl/modn_counter_if.sv | 27 ++
 rtl/modn_counter.sv | 90 +++++++++
 tb/tb_modn_counter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modn_counter_if.sv
// rtl/modn_counter_if.sv - control/status bundle for the modulo-N up/down counter
interface modn_counter_if #(
   parameter int WIDTH = 2
) ();
   logic             incr;
   logic             decr;
   logic             load;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] q;
   logic             tc_up;
   logic             tc_dn;
   logic             carry;
   logic             borrow;
   logic             ovf;

   // Sequencer side: issues count/load requests and watches the count.
   modport master (
      output incr, decr, load, ld_val,
      input  q, tc_up, tc_dn, carry, borrow, ovf
   );

   // Counter side.
   modport slave (
      input  incr, decr, load, ld_val,
      output q, tc_up, tc_dn, carry, borrow, ovf
   );
endinterface

// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - modulo-N up/down counter with load, terminal counts and wrap pulses; MODN_COUNTER_STICKY_EN adds sticky ovf
module modn_counter #(
   parameter int WIDTH   = 2,
   parameter int MODULUS = 4
) (
   input logic          clk,
   input logic          reset,
   modn_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_cur;
   logic [WIDTH-1:0] ld_sat;
   logic [WIDTH-1:0] q_nx;
   logic             carry_r;
   logic             borrow_r;
   logic             carry_nx;
   logic             borrow_nx;

   // An out-of-range count (only via X) is treated as the top of the range.
   always_comb q_cur = (q_r > MAX) ? MAX : q_r;

   // Load values beyond the modulus clamp to the top of the range.
   always_comb ld_sat = (bus.ld_val > MAX) ? MAX : bus.ld_val;

   // Next count and wrap pulses: load, then simultaneous up/down (hold), then up, then down.
   always_comb begin
      q_nx      = q_cur;
      carry_nx  = 1'b0;
      borrow_nx = 1'b0;
      if (bus.load) begin
         q_nx = ld_sat;
      end else if (bus.incr && !bus.decr) begin
         if (q_cur == MAX) begin
            q_nx     = '0;
            carry_nx = 1'b1;
         end else begin
            q_nx = q_cur + ONE;
         end
      end else if (bus.decr && !bus.incr) begin
         if (q_cur == '0) begin
            q_nx      = MAX;
            borrow_nx = 1'b1;
         end else begin
            q_nx = q_cur - ONE;
         end
      end
   end

   // Count and one-cycle wrap pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r      <= '0;
         carry_r  <= 1'b0;
         borrow_r <= 1'b0;
      end else begin
         q_r      <= q_nx;
         carry_r  <= carry_nx;
         borrow_r <= borrow_nx;
      end
   end

`ifdef MODN_COUNTER_STICKY_EN
   logic ovf_r;

   // Sticky wrap flag: set with any wrap pulse, cleared only by load or reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (bus.load) begin
         ovf_r <= 1'b0;
      end else if (carry_nx || borrow_nx) begin
         ovf_r <= 1'b1;
      end
   end

   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.q      = q_r;
   assign bus.carry  = carry_r;
   assign bus.borrow = borrow_r;
   // Terminal counts decode the register directly so cascades stay single-edge.
   assign bus.tc_up  = (q_r == MAX);
   assign bus.tc_dn  = (q_r == '0);
endmodule

// File: tb/tb_modn_counter.sv
// tb/tb_modn_counter.sv - directed-vector bench for modn_counter
module tb_modn_counter;
`ifdef MODN_COUNTER_STICKY_EN
   localparam int S = 1;
`else
   localparam int S = 0;
`endif

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   modn_counter_if #(.WIDTH(2)) bus_a ();
   modn_counter_if #(.WIDTH(4)) bus_b ();
   modn_counter_if #(.WIDTH(4)) bus_c0 ();
   modn_counter_if #(.WIDTH(4)) bus_c1 ();
   modn_counter_if #(.WIDTH(1)) bus_d ();

   modn_counter #(.WIDTH(2), .MODULUS(4))  u_a  (.clk(clk), .reset(reset), .bus(bus_a));
   modn_counter #(.WIDTH(4), .MODULUS(10)) u_b  (.clk(clk), .reset(reset), .bus(bus_b));
   modn_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (.clk(clk), .reset(reset), .bus(bus_c0));
   modn_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (.clk(clk), .reset(reset), .bus(bus_c1));
   modn_counter #(.WIDTH(1), .MODULUS(2))  u_d  (.clk(clk), .reset(reset), .bus(bus_d));

   // High decade of the cascade follows the low decade's terminal count.
   assign bus_c1.incr   = bus_c0.incr & bus_c0.tc_up;
   assign bus_c1.decr   = bus_c0.decr & bus_c0.tc_dn;
   assign bus_c1.load   = 1'b0;
   assign bus_c1.ld_val = '0;

   logic [31:0] qa, ca, ba, tua, tda, oa;
   logic [31:0] qb, cb, bb, tub, tdb;
   logic [31:0] qc0, qc1, cc0, cc1;
   logic [31:0] qd, cd;
   assign qa  = 32'(bus_a.q);
   assign ca  = 32'(bus_a.carry);
   assign ba  = 32'(bus_a.borrow);
   assign tua = 32'(bus_a.tc_up);
   assign tda = 32'(bus_a.tc_dn);
   assign oa  = 32'(bus_a.ovf);
   assign qb  = 32'(bus_b.q);
   assign cb  = 32'(bus_b.carry);
   assign bb  = 32'(bus_b.borrow);
   assign tub = 32'(bus_b.tc_up);
   assign tdb = 32'(bus_b.tc_dn);
   assign qc0 = 32'(bus_c0.q);
   assign qc1 = 32'(bus_c1.q);
   assign cc0 = 32'(bus_c0.carry);
   assign cc1 = 32'(bus_c1.carry);
   assign qd  = 32'(bus_d.q);
   assign cd  = 32'(bus_d.carry);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int exp_qa [6] = '{1, 2, 3, 0, 1, 2};
   int exp_ca [6] = '{0, 0, 0, 1, 0, 0};
   int exp_ta [6] = '{0, 0, 1, 0, 0, 0};
   int exp_qd [6] = '{1, 0, 1, 0, 1, 0};
   int exp_cd [6] = '{0, 1, 0, 1, 0, 1};
   int cnt_hi;
   int cnt_lo;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus_a.incr = 0;  bus_a.decr = 0;  bus_a.load = 0;  bus_a.ld_val = '0;
      bus_b.incr = 0;  bus_b.decr = 0;  bus_b.load = 0;  bus_b.ld_val = '0;
      bus_c0.incr = 0; bus_c0.decr = 0; bus_c0.load = 0; bus_c0.ld_val = '0;
      bus_d.incr = 0;  bus_d.decr = 0;  bus_d.load = 0;  bus_d.ld_val = '0;
      step();
      step();

      // reset state
      check("rst_qa", qa, 0);
      check("rst_ca", ca, 0);
      check("rst_ba", ba, 0);
      check("rst_oa", oa, 0);
      check("rst_tda", tda, 1);
      check("rst_tua", tua, 0);
      check("rst_qb", qb, 0);
      check("rst_tub", tub, 0);

      // count up MOD4 and MOD2 from reset
      reset = 1'b0;
      bus_a.incr = 1;
      bus_d.incr = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("up_qa_%0d", i), qa, 32'(exp_qa[i]));
         check($sformatf("up_ca_%0d", i), ca, 32'(exp_ca[i]));
         check($sformatf("up_tua_%0d", i), tua, 32'(exp_ta[i]));
         check($sformatf("up_qd_%0d", i), qd, 32'(exp_qd[i]));
         check($sformatf("up_cd_%0d", i), cd, 32'(exp_cd[i]));
      end
      check("up_oa", oa, 32'(S));
      bus_a.incr = 0;
      bus_d.incr = 0;

      // MOD10 down from 0, hold on incr&decr, up through wrap
      bus_b.decr = 1;
      step();
      check("dn_q9", qb, 9);
      check("dn_b9", bb, 1);
      check("dn_tu9", tub, 1);
      check("dn_c9", cb, 0);
      step();
      check("dn_q8", qb, 8);
      check("dn_b8", bb, 0);
      step();
      check("dn_q7", qb, 7);
      bus_b.incr = 1;
      step();
      check("both_q", qb, 7);
      check("both_b", bb, 0);
      check("both_c", cb, 0);
      bus_b.decr = 0;
      step();
      check("upb_q8", qb, 8);
      step();
      check("upb_q9", qb, 9);
      step();
      check("upb_q0", qb, 0);
      check("upb_c0", cb, 1);
      check("upb_td0", tdb, 1);

      // load clamp, then load priority over incr
      bus_b.incr = 0;
      bus_b.load = 1;
      bus_b.ld_val = 4'd12;
      step();
      check("ld_clamp_q", qb, 9);
      check("ld_clamp_c", cb, 0);
      bus_b.ld_val = 4'd5;
      bus_b.incr = 1;
      step();
      check("ld_pri_q", qb, 5);
      bus_b.incr = 0;
      bus_b.ld_val = 4'd7;
      step();
      check("ld7_q", qb, 7);

      // asynchronous reset mid-cycle while load is active
      #2;
      reset = 1'b1;
      #1;
      check("arst_qb", qb, 0);
      check("arst_cb", cb, 0);
      check("arst_tdb", tdb, 1);
      check("arst_qa", qa, 0);
      step();
      check("arst_hold_qb", qb, 0);
      bus_b.load = 0;
      reset = 1'b0;

      // two-decade cascade, 100 edges
      cnt_hi = 0;
      cnt_lo = 0;
      bus_c0.incr = 1;
      for (int e = 1; e <= 100; e++) begin
         step();
         cnt_hi += int'(cc1);
         cnt_lo += int'(cc0);
         if (e == 99) begin
            check("cas99_lo", qc0, 9);
            check("cas99_hi", qc1, 9);
         end
      end
      bus_c0.incr = 0;
      check("cas_lo", qc0, 0);
      check("cas_hi", qc1, 0);
      check("cas_hi_pulses", 32'(cnt_hi), 1);
      check("cas_lo_pulses", 32'(cnt_lo), 10);

      // sticky overflow on MOD4 (expected 0 without the macro)
      bus_a.incr = 1;
      repeat (3) step();
      check("ovf_pre", oa, 0);
      step();
      check("ovf_wrap_q", qa, 0);
      check("ovf_set", oa, 32'(S));
      bus_a.incr = 0;
      repeat (10) step();
      check("ovf_hold", oa, 32'(S));
      check("ovf_hold_c", ca, 0);
      bus_a.load = 1;
      bus_a.ld_val = 2'd0;
      step();
      check("ovf_clr", oa, 0);
      check("ovf_clr_q", qa, 0);
      bus_a.load = 0;
      bus_a.incr = 1;
      repeat (7) step();
      check("ovf_q3", qa, 3);
      check("ovf_again", oa, 32'(S));
      bus_a.load = 1;
      bus_a.ld_val = 2'd2;
      step();
      check("ovf_ldwin_q", qa, 2);
      check("ovf_ldwin_o", oa, 0);
      check("ovf_ldwin_c", ca, 0);

      // down-wrap at full-range modulus
      bus_a.load = 0;
      bus_a.incr = 0;
      bus_a.decr = 1;
      step();
      check("dna_q1", qa, 1);
      step();
      check("dna_q0", qa, 0);
      step();
      check("dna_q3", qa, 3);
      check("dna_b", ba, 1);
      check("dna_c", ca, 0);
      check("dna_o", oa, 32'(S));
      step();
      check("dna_q2", qa, 2);
      check("dna_b_off", ba, 0);
      check("dna_o_keep", oa, 32'(S));
      bus_a.decr = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
